// File: rtl/debounce_pkg.sv
// Shared constants, event record and helpers for the debounce_bank channels.
package debounce_pkg;

    localparam int DEBOUNCE_DEPTH_DEF = 6;
    localparam int DEBOUNCE_HOLD_DEF  = 500;

    typedef struct packed {
        logic rise;
        logic fall;
    } chan_evt_t;

    function automatic int hold_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single debounce channel: 2-flop synchroniser, tick-sampled history, clean level,
// rise/fall pulses and, with DEBOUNCE_HOLD_EN defined, a saturating long-press counter.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEPTH      = DEBOUNCE_DEPTH_DEF,
    parameter int HOLD_TICKS = DEBOUNCE_HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic msec_pulse,
    input  logic pb,
    output logic clean_pb,
    output logic rise,
    output logic fall,
    output logic hold
);

    logic [1:0]       sync_q, sync_d;
    logic [DEPTH-2:0] hist_q, hist_d;
    logic [DEPTH-1:0] h_next;
    logic             stable;
    logic             clean_q, clean_d;
    chan_evt_t        evt_q, evt_d;

    // Only DEPTH-1 past samples are ever read back, so the oldest bit of h_next is dropped.
    always_comb begin
        sync_d  = {sync_q[0], pb};
        h_next  = {hist_q, sync_q[1]};
        stable  = (&h_next) || (~|h_next);
        hist_d  = hist_q;
        clean_d = clean_q;
        evt_d   = '0;
        if (msec_pulse) begin
            hist_d = h_next[DEPTH-2:0];
            if (stable && (h_next[0] != clean_q)) begin
                clean_d    = h_next[0];
                evt_d.rise = h_next[0];
                evt_d.fall = ~h_next[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= '0;
            clean_q <= 1'b0;
            evt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            clean_q <= clean_d;
            evt_q   <= evt_d;
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int             CW       = hold_width(HOLD_TICKS);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(HOLD_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_q, hold_d;

    // Counting needs clean high before and after the edge, so the setting tick is skipped
    // and a release tick can never raise hold alongside fall.
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = 1'b0;
        if (!clean_q || !clean_d) begin
            cnt_d = '0;
        end else if (msec_pulse && (cnt_q != HOLD_MAX)) begin
            cnt_d  = cnt_q + CW'(1);
            hold_d = ((cnt_q + CW'(1)) == HOLD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;
`else
    assign hold = 1'b0;
`endif

    assign clean_pb = clean_q;
    assign rise     = evt_q.rise;
    assign fall     = evt_q.fall;

endmodule

// File: rtl/debounce_bank.sv
// NCH-channel debouncer bank on a shared millisecond tick; long-press events are
// built only when DEBOUNCE_HOLD_EN is defined, otherwise hold is tied low.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEPTH      = DEBOUNCE_DEPTH_DEF,
    parameter int HOLD_TICKS = DEBOUNCE_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           msec_pulse,
    input  logic [NCH-1:0] pb,
    output logic [NCH-1:0] clean_pb,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] hold
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .DEPTH      (DEPTH),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .msec_pulse (msec_pulse),
            .pb         (pb[i]),
            .clean_pb   (clean_pb[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .hold       (hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Table-driven bench for debounce_bank (NCH=4, DEPTH=6, HOLD_TICKS=20); hold
// expectations follow whether DEBOUNCE_HOLD_EN is defined.
module tb_debounce_bank;

    logic       clk;
    logic       rst;
    logic       msec_pulse;
    logic [3:0] pb;
    logic [3:0] clean_pb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hold;

    int num_compared   = 0;
    int num_mismatched = 0;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [3:0] HOLD_EXP = 4'h4;
`else
    localparam logic [3:0] HOLD_EXP = 4'h0;
`endif

    typedef struct {
        logic [3:0] pb;
        int         nticks;
        logic [3:0] exp_clean;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        logic [3:0] exp_hold;
    } vec_t;

    vec_t vecs[22];

    debounce_bank #(
        .NCH        (4),
        .DEPTH      (6),
        .HOLD_TICKS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msec_pulse (msec_pulse),
        .pb         (pb),
        .clean_pb   (clean_pb),
        .rise       (rise),
        .fall       (fall),
        .hold       (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        num_compared++;
        if (act !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // New pin levels are given two clocks to clear the synchroniser before the next tick.
    task automatic applyStimulus(input logic [3:0] value);
        pb = value;
        repeat (2) @(negedge clk);
    endtask

    task automatic doTick();
        msec_pulse = 1'b1;
        @(negedge clk);
        msec_pulse = 1'b0;
    endtask

    // Events are expected only on the row's final tick; every earlier tick must be quiet.
    task automatic runRow(input int idx);
        vec_t v;
        logic last;
        v = vecs[idx];
        applyStimulus(v.pb);
        for (int t = 1; t <= v.nticks; t++) begin
            doTick();
            last = (t == v.nticks);
            checkOutput($sformatf("row%0d tick%0d rise", idx, t), rise, last ? v.exp_rise : 4'h0);
            checkOutput($sformatf("row%0d tick%0d fall", idx, t), fall, last ? v.exp_fall : 4'h0);
            checkOutput($sformatf("row%0d tick%0d hold", idx, t), hold, last ? v.exp_hold : 4'h0);
            if (last)
                checkOutput($sformatf("row%0d clean", idx), clean_pb, v.exp_clean);
            @(negedge clk);
            if (last) begin
                checkOutput($sformatf("row%0d rise width", idx), rise, 4'h0);
                checkOutput($sformatf("row%0d fall width", idx), fall, 4'h0);
                checkOutput($sformatf("row%0d hold width", idx), hold, 4'h0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            pb     ticks clean  rise   fall   hold
        vecs[0]  = '{4'hF,  5,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[1]  = '{4'hF,  1,    4'hF,  4'hF,  4'h0,  4'h0};
        vecs[2]  = '{4'h0,  5,    4'hF,  4'h0,  4'h0,  4'h0};
        vecs[3]  = '{4'h0,  1,    4'h0,  4'h0,  4'hF,  4'h0};
        vecs[4]  = '{4'h1,  5,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[5]  = '{4'h0,  6,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[6]  = '{4'h2,  5,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[7]  = '{4'h2,  1,    4'h2,  4'h2,  4'h0,  4'h0};
        vecs[8]  = '{4'h2,  4,    4'h2,  4'h0,  4'h0,  4'h0};
        vecs[9]  = '{4'h0,  5,    4'h2,  4'h0,  4'h0,  4'h0};
        vecs[10] = '{4'h0,  1,    4'h0,  4'h0,  4'h2,  4'h0};
        vecs[11] = '{4'h0,  4,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[12] = '{4'h8,  6,    4'h8,  4'h8,  4'h0,  4'h0};
        vecs[13] = '{4'h1,  5,    4'h8,  4'h0,  4'h0,  4'h0};
        vecs[14] = '{4'h1,  1,    4'h1,  4'h1,  4'h8,  4'h0};
        vecs[15] = '{4'h4,  6,    4'h4,  4'h4,  4'h1,  4'h0};
        vecs[16] = '{4'h4,  19,   4'h4,  4'h0,  4'h0,  4'h0};
        vecs[17] = '{4'h4,  1,    4'h4,  4'h0,  4'h0,  HOLD_EXP};
        vecs[18] = '{4'h4,  20,   4'h4,  4'h0,  4'h0,  4'h0};
        vecs[19] = '{4'h6,  6,    4'h6,  4'h2,  4'h0,  4'h0};
        vecs[20] = '{4'h6,  5,    4'h0,  4'h0,  4'h0,  4'h0};
        vecs[21] = '{4'h6,  1,    4'h6,  4'h6,  4'h0,  4'h0};

        rst        = 1'b1;
        msec_pulse = 1'b0;
        pb         = 4'hF;
        repeat (3) @(negedge clk);
        checkOutput("reset clean", clean_pb, 4'h0);
        checkOutput("reset rise", rise, 4'h0);
        checkOutput("reset fall", fall, 4'h0);
        checkOutput("reset hold", hold, 4'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            runRow(i);

        // One-clock reset with a coincident tick while channels 1 and 2 are held high.
        rst        = 1'b1;
        msec_pulse = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        msec_pulse = 1'b0;
        checkOutput("midreset clean", clean_pb, 4'h0);
        checkOutput("midreset fall", fall, 4'h0);
        checkOutput("midreset rise", rise, 4'h0);
        checkOutput("midreset hold", hold, 4'h0);
        @(negedge clk);
        checkOutput("midreset fall after", fall, 4'h0);

        for (int i = 20; i < 22; i++)
            runRow(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
